// File: rtl/zframe_reader_pkg.sv
// Shared constants for the framebuffer scan-out reader: RGB565 colour table,
// SDRAM/pixel widths and the fetch FSM state encoding.
package zframe_reader_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int PIX_W        = 16;
    localparam int PIX_CNT_W    = 17;   // covers 480*272 = 130560 pixels

    typedef logic [SDRAM_ADDR_W-1:0] sdram_addr_t;
    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic [PIX_CNT_W-1:0]    pix_cnt_t;

    // RGB565 colour table
    localparam pix_t COLOR_BLACK = 16'h0000;
    localparam pix_t COLOR_WHITE = 16'hFFFF;
    localparam pix_t COLOR_RED   = 16'hF800;
    localparam pix_t COLOR_GREEN = 16'h07E0;
    localparam pix_t COLOR_BLUE  = 16'h001F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_ABORT = 3'd4
    } state_e;

endpackage

// File: rtl/zframe_reader_fifo.sv
// zpix_fifo: small synchronous FIFO with flush. rdata_o always shows the head
// word (first-word-available), so a pop and its data share one cycle.
module zpix_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    // flush beats both push and pop in the same cycle
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i & ~flush_i & ~full_o;
    assign do_pop  = pop_i & ~flush_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/zframe_reader.sv
// zframe_reader: framebuffer scan-out reader. Fetches RGB565 pixels linearly
// from SDRAM into a pixel FIFO and serves one pixel per iPix_Req.
// Optional macro ZREADER_DBUF_EN: front buffer chosen by iBuf_Sel at each
// accepted frame start (FB_BASE1 when set); otherwise always FB_BASE0.
module zframe_reader
    import zframe_reader_pkg::*;
#(
    parameter int          H_ACTIVE   = 480,
    parameter int          V_ACTIVE   = 272,
    parameter int          FIFO_DEPTH = 16,
    parameter sdram_addr_t FB_BASE0   = 24'h000000,
    parameter sdram_addr_t FB_BASE1   = 24'h040000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    iFrame_Start,
    input  logic                    iBuf_Sel,
    output logic [SDRAM_ADDR_W-1:0] oSDRAM_Rd_Addr,
    output logic                    oSDRAM_Rd_Req,
    input  logic                    iSDRAM_Rd_Done,
    input  logic [PIX_W-1:0]        iSDRAM_Rd_Data,
    input  logic                    iPix_Req,
    output logic [PIX_W-1:0]        oPix_Data,
    output logic                    oPix_Valid,
    output logic                    oUnderflow,
    output logic                    oFrame_Fetched
);
    localparam pix_cnt_t TOTAL = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam int       FCW   = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    pix_cnt_t    cnt_q, cnt_d;
    sdram_addr_t base_q, base_d, addr_q, addr_d, base_sel;
    logic        req_q, req_d, fetched_q, fetched_d;
    logic        uf_q, uf_d, pix_vld_q, pix_vld_d;
    pix_t        pix_data_q, pix_data_d;

    logic           fs_acc, abort_done, clr, pix_req;
    logic           fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FCW-1:0] fifo_cnt;
    pix_t           fifo_rdata;

`ifdef ZREADER_DBUF_EN
    assign base_sel = iBuf_Sel ? FB_BASE1 : FB_BASE0;
`else
    sdram_addr_t unused_base1;
    logic        unused_buf_sel;
    assign unused_base1   = FB_BASE1;
    assign unused_buf_sel = iBuf_Sel;
    assign base_sel       = FB_BASE0;
`endif

    // clr covers both a direct restart and the deferred restart once an
    // aborted read has drained; it flushes the FIFO and clears frame status
    assign fs_acc     = iFrame_Start & en;
    assign abort_done = (state_q == S_ABORT) & iSDRAM_Rd_Done;
    assign clr        = fs_acc | abort_done;
    assign pix_req    = iPix_Req & en;
    assign fifo_push  = (state_q == S_WAIT) & iSDRAM_Rd_Done & ~fs_acc & ~fifo_full;
    assign fifo_pop   = pix_req & ~clr & ~fifo_empty;

    zpix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (iSDRAM_Rd_Data),
        .pop_i   (fifo_pop),
        .flush_i (clr),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // fetch FSM: next state, request, address and frame counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        addr_d    = addr_q;
        req_d     = req_q;
        fetched_d = fetched_q;
        unique case (state_q)
            S_IDLE: if (fs_acc) state_d = S_FILL;
            S_FILL: begin
                if (fs_acc) begin
                    state_d = S_FILL;
                end else if (en) begin
                    if (cnt_q >= TOTAL) begin
                        fetched_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (fifo_cnt < FCW'(FIFO_DEPTH)) begin
                        // room for one more word once this read lands
                        req_d   = 1'b1;
                        addr_d  = base_q + {{(SDRAM_ADDR_W-PIX_CNT_W){1'b0}}, cnt_q};
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // a read in flight is always completed, even with en low
                if (iSDRAM_Rd_Done) begin
                    req_d   = 1'b0;
                    state_d = fs_acc ? S_FILL : S_GAP;
                    if (!fs_acc) cnt_d = cnt_q + PIX_CNT_W'(1);
                end else if (fs_acc) begin
                    state_d = S_ABORT;
                end
            end
            S_GAP:   if (fs_acc || en) state_d = S_FILL;
            S_ABORT: begin
                if (iSDRAM_Rd_Done) begin
                    req_d   = 1'b0;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fs_acc) base_d = base_sel;
        if (clr) begin
            cnt_d     = '0;
            fetched_d = 1'b0;
        end
    end

    // pixel side: serve head, or black on underflow/flush
    always_comb begin
        pix_vld_d  = pix_req;
        pix_data_d = pix_data_q;
        uf_d       = uf_q;
        if (pix_req) begin
            if (clr || fifo_empty) begin
                pix_data_d = COLOR_BLACK;
                if (!clr) uf_d = 1'b1;
            end else begin
                pix_data_d = fifo_rdata;
            end
        end
        if (clr) uf_d = 1'b0;
    end

    // fetch-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            fetched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            fetched_q <= fetched_d;
        end
    end

    // pixel-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data_q <= COLOR_BLACK;
            pix_vld_q  <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            pix_data_q <= pix_data_d;
            pix_vld_q  <= pix_vld_d;
            uf_q       <= uf_d;
        end
    end

    assign oSDRAM_Rd_Addr = addr_q;
    assign oSDRAM_Rd_Req  = req_q;
    assign oPix_Data      = pix_data_q;
    assign oPix_Valid     = pix_vld_q;
    assign oUnderflow     = uf_q;
    assign oFrame_Fetched = fetched_q;

endmodule

// File: tb/tb_zframe_reader.sv
// Scoreboard bench for zframe_reader on a small 16x4 frame. A reference model
// keeps the expected FIFO contents as a queue; an SDRAM model answers reads.
module tb_zframe_reader;
    import zframe_reader_pkg::*;

    localparam int H = 16, V = 4, TOT = H * V, DEPTH = 16;
    localparam logic [23:0] B0 = 24'h000000, B1 = 24'h040000;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, fs = 1'b0, sel = 1'b0;
    logic        done = 1'b0, pix_req = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic [23:0] rd_addr;
    logic        rd_req, pix_vld, uf, fetched;
    logic [15:0] pix_data;

    always #5 clk = ~clk;

    zframe_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH),
                    .FB_BASE0(B0), .FB_BASE1(B1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .iFrame_Start(fs), .iBuf_Sel(sel),
        .oSDRAM_Rd_Addr(rd_addr), .oSDRAM_Rd_Req(rd_req),
        .iSDRAM_Rd_Done(done), .iSDRAM_Rd_Data(rd_data),
        .iPix_Req(pix_req), .oPix_Data(pix_data), .oPix_Valid(pix_vld),
        .oUnderflow(uf), .oFrame_Fetched(fetched));

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [15:0] d; logic uf; } exp_t;
    logic [15:0] mq[$];          // pixels that should sit in the FIFO
    exp_t        eq[$];          // expected pixel responses
    int          n_m = 0;        // pixels fetched this frame
    logic [23:0] base_m = B0;
    bit          uf_m = 0, aborting = 0, req_seen = 0;
    bit          f_m, clr_m;
    exp_t        e_m;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete(); n_m = 0; uf_m = 0; aborting = 0;
        end else begin
            f_m   = fs & en;
            clr_m = f_m | (aborting & done);
            e_m   = '0;
            if (pix_req & en) begin
                if (clr_m) e_m.d = COLOR_BLACK;
                else if (mq.size() == 0) begin e_m.d = COLOR_BLACK; uf_m = 1; end
                else e_m.d = mq.pop_front();
            end
            if (f_m) begin
                mq.delete(); uf_m = 0; n_m = 0;
`ifdef ZREADER_DBUF_EN
                base_m = sel ? B1 : B0;
`else
                base_m = B0;
`endif
                // a frame start with a read in flight throws that read away
                aborting = req_seen & ~done;
            end else if (aborting & done) begin
                mq.delete(); uf_m = 0; n_m = 0; aborting = 0;
            end else if (done) begin
                mq.push_back(rd_data); n_m++;
            end
            if (pix_req & en) begin e_m.uf = uf_m; eq.push_back(e_m); end
        end
    end

    // ---------------- SDRAM model ----------------
    int          lat = 3, lat_cur = 0, cnt_l = 0, nreq = 0;
    bit          busy = 0, rand_lat = 0, force_abcd = 0;
    logic [23:0] addr_l = '0, last_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0; done = 0; req_seen = 0;
        end else begin
            if (done) begin
                done = 0; busy = 0;
                chk("req_drop_after_done", 32'(rd_req), 32'd0);
            end else if (rd_req) begin
                if (!busy) begin
                    busy = 1; addr_l = rd_addr; last_addr = rd_addr; nreq++;
                    lat_cur = rand_lat ? int'($urandom_range(1, 6)) : lat;
                    cnt_l = lat_cur;
                    chk("rd_addr", 32'(rd_addr), 32'(24'(base_m + 24'(n_m))));
                    chk("fifo_room", 32'(mq.size() < DEPTH), 32'd1);
                    chk("frame_not_done", 32'(n_m < TOT), 32'd1);
                    chk("fetched_low", 32'(fetched), 32'd0);
                end else begin
                    chk("addr_stable", 32'(rd_addr), 32'(addr_l));
                end
                cnt_l--;
                if (cnt_l <= 0) begin
                    done = 1;
                    rd_data = force_abcd ? 16'hABCD : addr_l[15:0];
                    force_abcd = 0;
                end
            end
            req_seen = rd_req;
        end
    end

    // ---------------- monitor ----------------
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && pix_vld) begin
            if (eq.size() == 0) begin
                checks++; errors++;
                $display("FAIL pix_unexpected: got valid data %0h expected no response", pix_data);
            end else begin
                m_e = eq.pop_front();
                chk("pix_data", 32'(pix_data), 32'(m_e.d));
                chk("underflow", 32'(uf), 32'(m_e.uf));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic frame_start(input logic s);
        en = 1; fs = 1; sel = s;
        @(negedge clk);
        fs = 0;
    endtask

    // park the reader (en low) once any read in flight has landed
    task automatic quiesce();
        pix_req = 0; en = 0;
        for (int c = 0; c < 100 && (rd_req || busy); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("quiesce_req", 32'(rd_req), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_req", 32'(rd_req), 32'd0);
        chk("rst_pix", 32'(pix_data), 32'd0);
        chk("rst_vld", 32'(pix_vld), 32'd0);
        chk("rst_uf", 32'(uf), 32'd0);
        chk("rst_fetched", 32'(fetched), 32'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // fill to FIFO depth, then drain the frame without underflow
        en = 1; lat = 3; nreq = 0;
        frame_start(0);
        repeat (150) @(negedge clk);
        chk("fill_reqs", 32'(nreq), 32'(DEPTH));
        chk("fill_req_idle", 32'(rd_req), 32'd0);
        for (int c = 0; c < 4000 && !(n_m == TOT && mq.size() == 0); c++) begin
            pix_req = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        pix_req = 0;
        for (int c = 0; c < 30 && !fetched; c++) @(negedge clk);
        chk("frame_pixels", 32'(n_m), 32'(TOT));
        chk("frame_fetched", 32'(fetched), 32'd1);
        chk("frame_no_uf", 32'(uf), 32'd0);

        // slow SDRAM with pops every cycle: sticky underflow
        quiesce();
        lat = 20;
        frame_start(0);
        pix_req = 1;
        repeat (100) @(negedge clk);
        pix_req = 0;
        chk("uf_set", 32'(uf), 32'd1);
        repeat (10) @(negedge clk);
        chk("uf_sticky", 32'(uf), 32'd1);

        // frame start while a read is outstanding
        quiesce();
        lat = 8; nreq = 0;
        frame_start(0);
        pix_req = 1;
        for (int c = 0; c < 50 && !busy; c++) begin @(negedge clk); #1; end
        chk("abort_req_out", 32'(busy), 32'd1);
        force_abcd = 1; fs = 1;
        @(negedge clk);
        fs = 0;
        chk("abort_req_held", 32'(rd_req), 32'd1);
        for (int c = 0; c < 60 && nreq < 2; c++) @(negedge clk);
        chk("abort_next_req", 32'(nreq), 32'd2);
        chk("abort_base_addr", 32'(last_addr), 32'(B0));
        chk("abort_uf_empty", 32'(uf), 32'd1);

        // randomized traffic with restarts, enable gaps and buffer toggling
        quiesce();
        rand_lat = 1;
        frame_start(1'($urandom_range(0, 1)));
        for (int c = 0; c < 3000; c++) begin
            pix_req = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 19) != 0);
            sel     = 1'($urandom_range(0, 1));
            fs      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        fs = 0;
        quiesce();
        rand_lat = 0;
        chk("scoreboard_drained", 32'(eq.size()), 32'd0);

        // asynchronous reset during an outstanding read
        lat = 10;
        frame_start(0);
        for (int c = 0; c < 50 && !busy; c++) begin @(negedge clk); #1; end
        chk("rst_test_req_out", 32'(rd_req), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_addr", 32'(rd_addr), 32'd0);
        chk("arst_req", 32'(rd_req), 32'd0);
        chk("arst_pix", 32'(pix_data), 32'd0);
        chk("arst_vld", 32'(pix_vld), 32'd0);
        chk("arst_uf", 32'(uf), 32'd0);
        chk("arst_fetched", 32'(fetched), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1; nreq = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_no_req", 32'(nreq), 32'd0);
        chk("post_rst_req_low", 32'(rd_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
